// File: rtl/debouncer_pkg.sv
// ---------------------------------------------------------------------------
// debouncer_pkg
//
// Shared constants and width helpers for the multi-channel debouncer.
//
// Contents:
//   DEF_*          default timing for 125 MHz board builds
//                  (0.5 ms sample tick, 100 ms filter, 0.5 s long press,
//                  50 ms auto-repeat interval)
//   width_of()     bits needed for a counter that runs 0..n-1 (never below 1)
//   count_width()  bits needed for a counter that must hold the value n
// ---------------------------------------------------------------------------
package debouncer_pkg;

    localparam int DEF_WIDTH          = 4;
    localparam int DEF_SAMPLE_CNT_MAX = 62500;
    localparam int DEF_PULSE_CNT_MAX  = 200;
    localparam int DEF_HOLD_CNT_MAX   = 1000;
    localparam int DEF_REPEAT_CNT_MAX = 100;

    // A zero-width vector is illegal, so small ranges still get one bit.
    function automatic int width_of(input int range);
        return (range <= 1) ? 1 : $clog2(range);
    endfunction

    // Counters here saturate at, or wrap after reaching, their maximum value,
    // so they need room for max itself rather than max-1.
    function automatic int count_width(input int max_count);
        return width_of(max_count + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//
// One debounced channel: up/down integrator with hysteresis, edge pulses,
// and long-press / auto-repeat events. All state advances only on the
// shared sample tick, apart from the one-cycle level delay used for the
// edge pulses.
//
// Ports:
//   clk               system clock
//   rst               synchronous active-high reset
//   sample_tick       shared one-cycle sample strobe
//   sync              synchronised raw input for this channel
//   debounced         filtered level
//   pressed_pulse     one cycle, first cycle the level is high
//   released_pulse    one cycle, first cycle the level is low again
//   long_press_pulse  one cycle, hold reached HOLD_CNT_MAX ticks
//   repeat_pulse      one cycle, every REPEAT_CNT_MAX ticks after long press
// ---------------------------------------------------------------------------
module debounce_channel
    import debouncer_pkg::*;
#(
    parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX,
    parameter int HOLD_CNT_MAX   = DEF_HOLD_CNT_MAX,
    parameter int REPEAT_CNT_MAX = DEF_REPEAT_CNT_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_tick,
    input  logic sync,
    output logic debounced,
    output logic pressed_pulse,
    output logic released_pulse,
    output logic long_press_pulse,
    output logic repeat_pulse
);

    localparam int INT_CNT_WIDTH  = count_width(PULSE_CNT_MAX);
    localparam int HOLD_CNT_WIDTH = count_width(HOLD_CNT_MAX);
    localparam int REP_CNT_WIDTH  = count_width(REPEAT_CNT_MAX);

    localparam logic [INT_CNT_WIDTH-1:0]  INT_TOP  = INT_CNT_WIDTH'(PULSE_CNT_MAX);
    localparam logic [INT_CNT_WIDTH-1:0]  INT_ONE  = INT_CNT_WIDTH'(1);
    localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_TOP = HOLD_CNT_WIDTH'(HOLD_CNT_MAX);
    localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_ONE = HOLD_CNT_WIDTH'(1);
    localparam logic [REP_CNT_WIDTH-1:0]  REP_TOP  = REP_CNT_WIDTH'(REPEAT_CNT_MAX);
    localparam logic [REP_CNT_WIDTH-1:0]  REP_ONE  = REP_CNT_WIDTH'(1);
    localparam logic                      REPEAT_EN = (REPEAT_CNT_MAX > 0);

    logic [INT_CNT_WIDTH-1:0]  int_cnt;
    logic [INT_CNT_WIDTH-1:0]  int_cnt_nxt;
    logic                      level;
    logic                      level_nxt;
    logic                      level_d;
    logic [HOLD_CNT_WIDTH-1:0] hold_cnt;
    logic [REP_CNT_WIDTH-1:0]  rep_cnt;
    logic                      held;

    // Integrator and hysteresis level. The level only moves when the
    // integrator pins at one of its rails, so any run of disagreeing samples
    // shorter than PULSE_CNT_MAX is absorbed without a level change.
    always_comb begin
        int_cnt_nxt = int_cnt;
        level_nxt   = level;
        if (sample_tick) begin
            if (sync && (int_cnt < INT_TOP)) begin
                int_cnt_nxt = int_cnt + INT_ONE;
            end else if (!sync && (int_cnt != '0)) begin
                int_cnt_nxt = int_cnt - INT_ONE;
            end
            if (int_cnt_nxt == INT_TOP) begin
                level_nxt = 1'b1;
            end else if (int_cnt_nxt == '0) begin
                level_nxt = 1'b0;
            end
        end
    end

    // Hold/repeat bookkeeping keys off level_nxt so the tick that drops the
    // level also wipes the counters and cannot emit a late event pulse.
    // Counting needs level already high, so the rising tick itself is not
    // counted as part of the hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_cnt          <= '0;
            level            <= 1'b0;
            level_d          <= 1'b0;
            hold_cnt         <= '0;
            rep_cnt          <= '0;
            held             <= 1'b0;
            long_press_pulse <= 1'b0;
            repeat_pulse     <= 1'b0;
        end else begin
            int_cnt          <= int_cnt_nxt;
            level            <= level_nxt;
            level_d          <= level;
            long_press_pulse <= 1'b0;
            repeat_pulse     <= 1'b0;
            if (!level_nxt) begin
                hold_cnt <= '0;
                rep_cnt  <= '0;
                held     <= 1'b0;
            end else if (sample_tick && level) begin
                if (!held) begin
                    hold_cnt <= hold_cnt + HOLD_ONE;
                    if ((hold_cnt + HOLD_ONE) == HOLD_TOP) begin
                        held             <= 1'b1;
                        long_press_pulse <= 1'b1;
                    end
                end else if (REPEAT_EN) begin
                    if ((rep_cnt + REP_ONE) == REP_TOP) begin
                        rep_cnt      <= '0;
                        repeat_pulse <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + REP_ONE;
                    end
                end
            end
        end
    end

    // Reset clears level and level_d together, so a forced drop produces
    // no release pulse.
    assign debounced      = level;
    assign pressed_pulse  = level & ~level_d;
    assign released_pulse = ~level & level_d;

endmodule

// File: rtl/debouncer_multi_hold.sv
// ---------------------------------------------------------------------------
// debouncer_multi_hold
//
// Multi-channel button/switch debouncer with long-press and auto-repeat.
// Owns the per-channel 2-FF synchroniser and the shared sample-tick
// generator; one debounce_channel per input bit does the filtering.
//
// Ports:
//   clk               system clock (only clock)
//   rst               synchronous active-high reset
//   glitchy_signal    raw asynchronous inputs, WIDTH bits
//   debounced_signal  filtered level per channel
//   pressed_pulse     1-cycle pulse on debounced rising edge
//   released_pulse    1-cycle pulse on debounced falling edge
//   long_press_pulse  1-cycle pulse when hold reaches HOLD_CNT_MAX ticks
//   repeat_pulse      1-cycle pulse every REPEAT_CNT_MAX ticks after that
//   sample_tick       shared sample strobe, exported for observability
// ---------------------------------------------------------------------------
module debouncer_multi_hold
    import debouncer_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX,
    parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX,
    parameter int HOLD_CNT_MAX   = DEF_HOLD_CNT_MAX,
    parameter int REPEAT_CNT_MAX = DEF_REPEAT_CNT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] glitchy_signal,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] pressed_pulse,
    output logic [WIDTH-1:0] released_pulse,
    output logic [WIDTH-1:0] long_press_pulse,
    output logic [WIDTH-1:0] repeat_pulse,
    output logic             sample_tick
);

    localparam int TICK_CNT_WIDTH = width_of(SAMPLE_CNT_MAX);

    localparam logic [TICK_CNT_WIDTH-1:0] TICK_LAST = TICK_CNT_WIDTH'(SAMPLE_CNT_MAX - 1);
    localparam logic [TICK_CNT_WIDTH-1:0] TICK_ONE  = TICK_CNT_WIDTH'(1);

    logic [WIDTH-1:0]          sync_meta;
    logic [WIDTH-1:0]          sync;
    logic [TICK_CNT_WIDTH-1:0] tick_cnt;

    // Two-stage synchroniser; the first stage may go metastable and is
    // never looked at by anything except the second stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= glitchy_signal;
            sync      <= sync_meta;
        end
    end

    // Wrapping sample counter. The tick is registered, so it is high in the
    // cycle after the counter sits at its last value, giving a period of
    // exactly SAMPLE_CNT_MAX cycles with the first tick SAMPLE_CNT_MAX
    // cycles after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt    <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= (tick_cnt == TICK_LAST);
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TICK_ONE;
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_channel
        debounce_channel #(
            .PULSE_CNT_MAX  (PULSE_CNT_MAX),
            .HOLD_CNT_MAX   (HOLD_CNT_MAX),
            .REPEAT_CNT_MAX (REPEAT_CNT_MAX)
        ) u_channel (
            .clk              (clk),
            .rst              (rst),
            .sample_tick      (sample_tick),
            .sync             (sync[i]),
            .debounced        (debounced_signal[i]),
            .pressed_pulse    (pressed_pulse[i]),
            .released_pulse   (released_pulse[i]),
            .long_press_pulse (long_press_pulse[i]),
            .repeat_pulse     (repeat_pulse[i])
        );
    end

endmodule

// File: doc/debouncer_multi_hold.md
Name: debouncer_multi_hold

Overview:
- Next-generation multi-channel debouncer for buttons and switches.
- Per channel: 2-FF synchroniser, then an up/down integrator with hysteresis (symmetric press and release filtering), then press/release edge pulses and long-press/auto-repeat event pulses.
- Sits between raw board inputs and user-interface FSMs. All channels share one sample-tick generator.

Parameters:
- WIDTH, 4, number of independent channels.
- SAMPLE_CNT_MAX, 62500, clk cycles per sample tick (must be >= 2).
- PULSE_CNT_MAX, 200, integrator ceiling; number of consistent samples needed to change level (>= 1).
- HOLD_CNT_MAX, 1000, sample ticks of continuous debounced-high before long_press fires (>= 1).
- REPEAT_CNT_MAX, 100, sample ticks between repeat pulses after long_press; 0 disables repeat.
- TICK_CNT_WIDTH, $clog2(SAMPLE_CNT_MAX), wrapping counter width.
- INT_CNT_WIDTH, $clog2(PULSE_CNT_MAX+1), integrator width.
- HOLD_CNT_WIDTH, $clog2(HOLD_CNT_MAX+1), hold counter width.
- REP_CNT_WIDTH, $clog2(REPEAT_CNT_MAX+1) (min 1), repeat counter width.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- glitchy_signal  input  WIDTH  raw asynchronous inputs.
- debounced_signal  output  WIDTH  filtered level per channel.
- pressed_pulse  output  WIDTH  1-cycle pulse on debounced rising edge.
- released_pulse  output  WIDTH  1-cycle pulse on debounced falling edge.
- long_press_pulse  output  WIDTH  1-cycle pulse when hold reaches HOLD_CNT_MAX.
- repeat_pulse  output  WIDTH  1-cycle pulse every REPEAT_CNT_MAX ticks after long press.
- sample_tick  output  1  shared tick, exported for test observability.

Behaviour:
- Reset is synchronous and active-high; clk is the only clock. On rst, on the same edge:
  - all sync FFs, counters, levels and outputs clear to 0;
  - sample_tick = 0 and the wrapping counter = 0.
  - A mid-operation reset discards all state; no edge pulse is generated by the forced level drop.
- Synchroniser: sync = glitchy_signal delayed by 2 FFs. This adds 2 cycles of latency.
- Tick generator:
  - The counter runs 0..SAMPLE_CNT_MAX-1 and wraps.
  - sample_tick is registered and is high for exactly one cycle: the cycle after the counter equals SAMPLE_CNT_MAX-1.
  - Period is exactly SAMPLE_CNT_MAX cycles. The first tick is in cycle SAMPLE_CNT_MAX after reset release.
- Integrator, per channel, evaluated only in cycles where sample_tick = 1:
  - sync = 1 and cnt < PULSE_CNT_MAX: cnt + 1.
  - sync = 0 and cnt > 0: cnt - 1.
  - Otherwise hold (saturation at both ends).
- Level (hysteresis):
  - On the same edge that cnt updates, level is set to 1 if the next cnt == PULSE_CNT_MAX, and cleared to 0 if the next cnt == 0. Otherwise it holds.
  - debounced_signal = level.
  - A glitch shorter than PULSE_CNT_MAX samples never toggles level in either direction.
- Edge pulses:
  - pressed_pulse = level & ~level_d; released_pulse = ~level & level_d. level_d is level delayed one cycle.
  - Each pulse is high in the cycle after level changes, for exactly 1 cycle.
- Hold/repeat, per channel:
  - While level = 0: hold_cnt = 0, rep_cnt = 0, held = 0.
  - While level = 1, on each tick: if held = 0, hold_cnt + 1. When that increment reaches HOLD_CNT_MAX, set held = 1 and register long_press_pulse high for 1 cycle.
  - While held = 1 and REPEAT_CNT_MAX > 0, on each tick: rep_cnt + 1. When it reaches REPEAT_CNT_MAX, repeat_pulse is high for 1 cycle and rep_cnt returns to 0.
  - Release at any point clears hold/repeat state on the edge where level falls. There are no further event pulses after release.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Arithmetic is unsigned and widths are per parameters; no counter may ever overflow.

Decomposition:
- Package debouncer_pkg holds:
  - width helper constants (clog2 guards, including REP_CNT_WIDTH minimum of 1);
  - the default timing constants for 125 MHz board builds.
- Sub-module debounce_channel holds the integrator, level, edge detect and hold/repeat logic for one channel. The top generates WIDTH instances and owns the synchroniser and the shared tick generator.

Test Plan:
Settings for all scenarios: WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, HOLD_CNT_MAX=5, REPEAT_CNT_MAX=2. Drive inputs synchronously with clk.

- Reset/tick:
  - Stimulus: hold rst 3 cycles, then release.
  - Required: all outputs 0; sample_tick first high in cycle 4 after release, then every 4 cycles, width 1.
- Clean press on ch0:
  - Stimulus: hold glitchy_signal[0]=1 from just after a tick.
  - Required: debounced_signal[0] rises on the 3rd tick that samples sync=1; pressed_pulse[0] high exactly 1 cycle later; ch1 stays 0.
- Glitch rejection:
  - Stimulus: with ch0 low, pulse input high for 2 ticks, then low.
  - Required: cnt goes 0,1,2,1,0; no level change; no pulses. Mirror case with ch0 high and a 2-tick low: level stays 1.
- Long press and repeat:
  - Stimulus: hold ch0 high.
  - Required: long_press_pulse[0] fires on the 5th tick after level rises; repeat_pulse[0] fires every 2 ticks after that; release then gives released_pulse[0] and no further repeats.
- REPEAT_CNT_MAX=0:
  - Stimulus: same hold as above.
  - Required: exactly one long_press_pulse; repeat_pulse never asserts.
- Mid-press reset and simultaneity:
  - Stimulus: press both channels identically, assert rst while held.
  - Required: before reset, both pressed_pulse bits in the same cycle. After rst, all outputs 0 with no released_pulse, then re-debounce from cnt=0.
